vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 Parameters H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal front porch, sync and back porch in pixels.
REQ-003 Parameter V_VISIBLE, default 480, active lines per frame.
REQ-004 Parameters V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical front porch, sync and back porch in lines.
REQ-005 Parameter CLK_DIV, default 2, clk cycles per pixel; legal range 2..16.
REQ-006 clk  in  1  single system clock; all state is updated on its rising edge.
REQ-007 rst  in  1  reset, asynchronous and active-low.
REQ-008 color  in  24  {R,G,B} from the drawing logic for the coordinate presented one pixel period earlier.
REQ-009 pixel_x  out  16  horizontal counter, 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters (800).
REQ-010 pixel_y  out  16  vertical counter, 0..V_TOTAL-1, where V_TOTAL = sum of the V parameters (525).
REQ-011 pix_en  out  1  one-clk strobe marking each pixel advance.
REQ-012 hsync, vsync  out  1 each  sync outputs, active-low.
REQ-013 red, green, blue  out  8 each  registered pixel colour.
REQ-014 video_on  out  1  high while red, green and blue carry a visible pixel.
REQ-015 frame_start  out  1  one-clk pulse at the start of each frame.
REQ-016 frame_count  out  16  count of completed frames.

Function
REQ-017 A divider counter (0..CLK_DIV-1) shall assert pix_en for exactly one clk cycle in every CLK_DIV cycles, in the cycle when the divider equals CLK_DIV-1.
REQ-018 On each pix_en cycle, pixel_x shall increment; at H_TOTAL-1 it shall wrap to 0 and pixel_y shall increment.
REQ-019 pixel_y shall wrap from V_TOTAL-1 to 0 on the same edge that pixel_x wraps.
REQ-020 pixel_x and pixel_y shall change only on pix_en edges and shall be driven directly from registers (no combinational path).
REQ-021 Visible region: pixel_x < H_VISIBLE and pixel_y < V_VISIBLE.
REQ-022 Output stage, updated only on pix_en edges:
- video_on shall register the visible condition of the current counters.
- red, green, blue shall register color[23:16], color[15:8], color[7:0] when visible, else 0.
REQ-023 On the same pix_en edges, hsync shall register 0 when pixel_x is in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1], i.e. [656,751]; else it registers 1.
REQ-024 On the same pix_en edges, vsync shall register 0 when pixel_y is in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1], i.e. [490,491]; else it registers 1.
REQ-025 Latency: RGB, sync and video_on for coordinate (x,y) shall appear exactly one pixel period (CLK_DIV clk) after the counters present (x,y), so colour and sync stay mutually aligned.
REQ-026 color shall be sampled only on pix_en edges; changes between strobes shall have no effect.
REQ-027 frame_start shall be high for exactly one clk cycle, the cycle immediately after the edge on which the counters wrap from (799,524) to (0,0).
REQ-028 frame_count shall increment on the same edge frame_start is set, and shall wrap from 65535 to 0.
REQ-029 Non-pix_en cycles shall leave all counters and output registers unchanged.

Reset
REQ-030 When rst=0, asynchronously and without a clock edge:
- divider, pixel_x, pixel_y, frame_count, red, green, blue, video_on, frame_start and pix_en shall go to 0;
- hsync and vsync shall go to 1.
REQ-031 Assertion of rst mid-line or mid-frame shall abandon the frame; no frame_start shall be emitted for it.
REQ-032 After rst deasserts, the first pix_en shall occur on the CLK_DIV-th rising clk edge, and the first frame_start shall follow one full frame later.

Verification
REQ-033 Release reset with CLK_DIV=2 -> pix_en on every second clk; pixel_x reaches 799 then 0, and pixel_y becomes 1 at that same edge.
REQ-034 Run one full line -> hsync low for exactly 96 pixels, starting when pixel_x=656 has been registered; video_on high for exactly 640 pixels per visible line.
REQ-035 Run one full frame -> vsync low for exactly 2 lines (rows 490-491), frame_start pulses once (1 clk wide), frame_count increments 0 to 1.
REQ-036 Drive color=24'hFF0000 only while pixel_x=5 -> red=8'hFF on exactly one pixel period, starting one period later; drive color=24'h66FFFF while pixel_x=700 -> RGB remains 0.
REQ-037 Pulse rst=0 for 3 clk at pixel (300,200) with no clock edge needed -> all outputs at reset values immediately; after release, counting restarts at (0,0) and no spurious frame_start is emitted.
REQ-038 Force frame_count to 65535, then complete a frame -> frame_count=0 and frame_start still pulses.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Pixel bus between the VGA timing generator and the drawing logic / display side.
interface vga_timing_gen_if;
  logic [23:0] color;
  logic [15:0] pixel_x;
  logic [15:0] pixel_y;
  logic        pix_en;
  logic        hsync;
  logic        vsync;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        video_on;
  logic        frame_start;
  logic [15:0] frame_count;

  modport master (
    input  color,
    output pixel_x, pixel_y, pix_en, hsync, vsync,
    output red, green, blue, video_on, frame_start, frame_count
  );

  modport slave (
    output color,
    input  pixel_x, pixel_y, pix_en, hsync, vsync,
    input  red, green, blue, video_on, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, x/y counters, registered sync/colour stage
// delayed one pixel behind the counters, frame start strobe and frame counter.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned CLK_DIV   = 2
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_VISIBLE + H_FP;
  localparam int unsigned HS_END   = H_VISIBLE + H_FP + H_SYNC - 1;
  localparam int unsigned VS_START = V_VISIBLE + V_FP;
  localparam int unsigned VS_END   = V_VISIBLE + V_FP + V_SYNC - 1;
  localparam int unsigned DIV_W    = $clog2(CLK_DIV);
  localparam int unsigned CNT_W    = 16;

  logic [DIV_W-1:0] div_q;
  logic             pix_en_q;
  logic [CNT_W-1:0] x_q;
  logic [CNT_W-1:0] y_q;
  logic [CNT_W-1:0] frame_count_q;
  logic             frame_start_q;
  logic             hsync_q;
  logic             vsync_q;
  logic             video_on_q;
  logic [7:0]       red_q;
  logic [7:0]       green_q;
  logic [7:0]       blue_q;

  logic x_last_c;
  logic y_last_c;
  logic visible_c;
  logic hsync_c;
  logic vsync_c;

  // Decode of the coordinate currently held in the counters.
  always_comb begin
    x_last_c  = 1'b0;
    y_last_c  = 1'b0;
    visible_c = 1'b0;
    hsync_c   = 1'b1;
    vsync_c   = 1'b1;
    x_last_c  = (x_q == CNT_W'(H_TOTAL - 1));
    y_last_c  = (y_q == CNT_W'(V_TOTAL - 1));
    visible_c = (x_q < CNT_W'(H_VISIBLE)) && (y_q < CNT_W'(V_VISIBLE));
    if ((x_q >= CNT_W'(HS_START)) && (x_q <= CNT_W'(HS_END))) hsync_c = 1'b0;
    if ((y_q >= CNT_W'(VS_START)) && (y_q <= CNT_W'(VS_END))) vsync_c = 1'b0;
  end

  // pix_en is registered one cycle early so it is high exactly while div_q == CLK_DIV-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q    <= '0;
      pix_en_q <= 1'b0;
    end else begin
      if (div_q == DIV_W'(CLK_DIV - 1)) div_q <= '0;
      else                              div_q <= div_q + DIV_W'(1);
      pix_en_q <= (div_q == DIV_W'(CLK_DIV - 2));
    end
  end

  // Raster counters advance on pixel strobes; the output stage lags them by one pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q           <= '0;
      y_q           <= '0;
      frame_count_q <= '0;
      frame_start_q <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
    end else begin
      frame_start_q <= pix_en_q & x_last_c & y_last_c;
      if (pix_en_q) begin
        if (x_last_c) begin
          x_q <= '0;
          if (y_last_c) begin
            y_q           <= '0;
            frame_count_q <= frame_count_q + CNT_W'(1);
          end else begin
            y_q <= y_q + CNT_W'(1);
          end
        end else begin
          x_q <= x_q + CNT_W'(1);
        end
        hsync_q    <= hsync_c;
        vsync_q    <= vsync_c;
        video_on_q <= visible_c;
        red_q      <= visible_c ? vga.color[23:16] : 8'h00;
        green_q    <= visible_c ? vga.color[15:8]  : 8'h00;
        blue_q     <= visible_c ? vga.color[7:0]   : 8'h00;
      end
    end
  end

  assign vga.pixel_x     = x_q;
  assign vga.pixel_y     = y_q;
  assign vga.pix_en      = pix_en_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video_on    = video_on_q;
  assign vga.red         = red_q;
  assign vga.green       = green_q;
  assign vga.blue        = blue_q;
  assign vga.frame_start = frame_start_q;
  assign vga.frame_count = frame_count_q;

endmodule
